// File: rtl/alu_share_arbiter.sv
// Two-requester front end for a single shared 32-bit ALU: round-robin grant, registered
// operands, one evaluate cycle, then the result is held until the owner accepts it.
module alu_share_arbiter #(
  parameter bit PRIO_INIT       = 1'b0,
  parameter bit ERR_ON_UNMAPPED = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_req_valid,
  output logic        a_req_ready,
  input  logic [3:0]  a_alu_op,
  input  logic [5:0]  a_func,
  input  logic [31:0] a_inp1,
  input  logic [31:0] a_inp2,
  output logic        a_resp_valid,
  input  logic        a_resp_ready,
  output logic [31:0] a_resp_data,
  output logic        a_resp_err,
  input  logic        b_req_valid,
  output logic        b_req_ready,
  input  logic [3:0]  b_alu_op,
  input  logic [5:0]  b_func,
  input  logic [31:0] b_inp1,
  input  logic [31:0] b_inp2,
  output logic        b_resp_valid,
  input  logic        b_resp_ready,
  output logic [31:0] b_resp_data,
  output logic        b_resp_err,
  output logic        busy,
  output logic        owner
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]  state;
  logic        prio;
  logic [3:0]  op_r;
  logic [5:0]  func_r;
  logic [31:0] inp1_r;
  logic [31:0] inp2_r;
  logic        unmapped_err;
  logic [31:0] alu_y;
  logic [31:0] result;

  // Pure function of the registered operands, so no result can leak from a prior operation.
  function automatic logic [31:0] alu_eval(input logic [3:0] op, input logic [5:0] fn,
                                           input logic [31:0] x, input logic [31:0] y);
    logic        big;
    logic [31:0] shl;
    logic [31:0] srl;
    logic [31:0] sra;
    logic [31:0] r;
    big = |y[31:5];
    shl = big ? 32'd0 : (x << y[4:0]);
    srl = big ? 32'd0 : (x >> y[4:0]);
    sra = big ? {32{x[31]}} : 32'($signed(x) >>> y[4:0]);
    case (op)
      4'b0001: begin
        case (fn)
          6'b000001: r = x - y;
          6'b000010: r = x & y;
          6'b000011: r = x | y;
          6'b000100: r = x ^ y;
          6'b000101: r = ~x;
          6'b000110: r = shl;
          6'b000111: r = sra;
          6'b001000: r = srl;
          default:   r = x + y;
        endcase
      end
      4'b0011: r = x - y;
      4'b0100: r = shl;
      4'b0101: r = sra;
      4'b0110: r = srl;
      4'b0111: r = x & y;
      4'b1000: r = x | y;
      4'b1001: r = x ^ y;
      default: r = x + y;
    endcase
    return r;
  endfunction

  always_comb begin
    a_req_ready  = (state == IDLE) && a_req_valid && (!b_req_valid || !prio);
    b_req_ready  = (state == IDLE) && b_req_valid && (!a_req_valid || prio);
    busy         = (state != IDLE);
    unmapped_err = (op_r >= 4'b1010) && ERR_ON_UNMAPPED;
    alu_y        = alu_eval(op_r, func_r, inp1_r, inp2_r);
    result       = unmapped_err ? 32'd0 : alu_y;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      prio         <= PRIO_INIT;
      owner        <= 1'b0;
      op_r         <= 4'd0;
      func_r       <= 6'd0;
      inp1_r       <= 32'd0;
      inp2_r       <= 32'd0;
      a_resp_valid <= 1'b0;
      a_resp_data  <= 32'd0;
      a_resp_err   <= 1'b0;
      b_resp_valid <= 1'b0;
      b_resp_data  <= 32'd0;
      b_resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (a_req_ready || b_req_ready) begin
            op_r   <= b_req_ready ? b_alu_op : a_alu_op;
            func_r <= b_req_ready ? b_func : a_func;
            inp1_r <= b_req_ready ? b_inp1 : a_inp1;
            inp2_r <= b_req_ready ? b_inp2 : a_inp2;
            owner  <= b_req_ready;
            prio   <= !b_req_ready;
            state  <= EXEC;
          end
        end
        EXEC: begin
          if (owner) begin
            b_resp_valid <= 1'b1;
            b_resp_data  <= result;
            b_resp_err   <= unmapped_err;
          end else begin
            a_resp_valid <= 1'b1;
            a_resp_data  <= result;
            a_resp_err   <= unmapped_err;
          end
          state <= RESP;
        end
        RESP: begin
          if (owner && b_resp_ready) begin
            b_resp_valid <= 1'b0;
            state        <= IDLE;
          end else if (!owner && a_resp_ready) begin
            a_resp_valid <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
